// File: rtl/dpb_arb_pkg.sv
// Shared types and RAM geometry for the dual-port block RAM port arbiter.
package dpb_arb_pkg;

  // Arbiter ownership state: no owner, or requester 0 / 1 currently owns the port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester identifier (0 = req0, 1 = req1).
  typedef logic req_id_t;

  // Geometry of the 8-bit x 2048 block RAM port pins.
  localparam int RAM_AD_W  = 14;
  localparam int RAM_DI_W  = 18;
  localparam int RAM_DO_W  = 8;
  localparam int RAM_DEPTH = 2048;

endpackage

// File: rtl/dpb_port_arbiter.sv
// Round-robin arbiter sharing one block RAM port between two requesters,
// with a bounded burst per owner and fixed 1-cycle read return.
module dpb_port_arbiter
  import dpb_arb_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter int          MAX_BURST = 4,
  parameter logic [2:0]  BLK_SEL   = 3'b000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic                r0_we,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [7:0]          r0_wdata,
  output logic                r0_rvalid,
  output logic [7:0]          r0_rdata,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic                r1_we,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [7:0]          r1_wdata,
  output logic                r1_rvalid,
  output logic [7:0]          r1_rdata,
  output logic                mem_ce,
  output logic                mem_oce,
  output logic                mem_wre,
  output logic [RAM_AD_W-1:0] mem_ad,
  output logic [RAM_DI_W-1:0] mem_di,
  output logic [2:0]          mem_blksel,
  output logic                mem_reset,
  input  logic [RAM_DO_W-1:0] mem_do
);

  localparam int             CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          last_q, last_d;
  logic             rd_pend_q, rd_pend_d;
  req_id_t          rd_tag_q, rd_tag_d;

  logic             gnt_vld;
  req_id_t          gnt_id;
  req_id_t          own_id;
  logic             own_v;
  logic             oth_v;
  logic             accept;
  logic             g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [7:0]       g_wdata;
  arb_state_t       gnt_state;

  // Grant selection: alternate on ties, keep the owner until its burst runs out
  // while the other requester waits.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    own_id  = (state_q == OWN1);
    own_v   = own_id ? r1_valid : r0_valid;
    oth_v   = own_id ? r0_valid : r1_valid;
    case (state_q)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_q;
        end else if (r0_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (r1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (own_v && ((cnt_q < CNT_MAX) || !oth_v)) begin
          gnt_vld = 1'b1;
          gnt_id  = own_id;
        end else if (oth_v) begin
          gnt_vld = 1'b1;
          gnt_id  = ~own_id;
        end
      end
      default: ;
    endcase
  end

  // Request fields of the granted requester.
  assign g_we      = gnt_id ? r1_we    : r0_we;
  assign g_addr    = gnt_id ? r1_addr  : r0_addr;
  assign g_wdata   = gnt_id ? r1_wdata : r0_wdata;
  assign gnt_state = gnt_id ? OWN1 : OWN0;

  // Nothing is accepted while reset is held.
  assign accept   = gnt_vld & ~RESET;
  assign r0_ready = accept & ~gnt_id;
  assign r1_ready = accept &  gnt_id;

  assign mem_ce     = accept;
  assign mem_wre    = accept &  g_we;
  assign mem_oce    = accept & ~g_we;
  assign mem_ad     = RAM_AD_W'(g_addr);
  assign mem_di     = RAM_DI_W'(g_wdata);
  assign mem_blksel = BLK_SEL;
  assign mem_reset  = RESET;

  // Read data comes straight from the RAM output register; rvalid marks the owner.
  assign r0_rvalid = rd_pend_q & ~rd_tag_q & ~RESET;
  assign r1_rvalid = rd_pend_q &  rd_tag_q & ~RESET;
  assign r0_rdata  = mem_do;
  assign r1_rdata  = mem_do;

  // Next ownership, burst count, tie-break memory and read-return tag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rd_pend_d = 1'b0;
    rd_tag_d  = rd_tag_q;
    if (accept) begin
      if (state_q == gnt_state) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        state_d = gnt_state;
        cnt_d   = CNT_W'(1);
        last_d  = gnt_id;
      end
      if (!g_we) begin
        rd_pend_d = 1'b1;
        rd_tag_d  = gnt_id;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State registers; last starts at 1 so req0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

endmodule
